sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Single-port controller for the board's 512K x 16 asynchronous SRAM; sits directly downstream of user logic inside chip and drives the ADR/DAT/RAMOE/RAMWE/RAMCS/RAMLB/RAMUB pins that chip currently parks.
- Converts a valid/ready request (read or write, one word) into correctly timed SRAM strobe sequences at 100 MHz and returns read data with a one-cycle response pulse.
- DAT tristate is resolved in chip from dat_out/dat_oe/dat_in; this block never drives a z value.

Parameters:
- ADDR_W, 19, SRAM word address width.
- DATA_W, 16, SRAM data width.
- RD_WAIT, 1, extra read-strobe cycles beyond the first (0..15).
- WR_WAIT, 1, extra WE-low cycles beyond the first (0..15).

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous reset, active high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  2  byte enables {upper, lower}, active high.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata is valid.
- rsp_rdata  out  DATA_W  read data.
- ram_adr  out  ADDR_W  to ADR.
- dat_out  out  DATA_W  to DAT output path.
- dat_in  in  DATA_W  from DAT input path.
- dat_oe  out  1  DAT output enable (1 = FPGA drives).
- ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n  out  1 each  active-low SRAM strobes.

Behaviour:
- All outputs registered. Reset values: req_ready=0 during rst, 1 in the first cycle after rst falls; rsp_valid=0; rsp_rdata=0; ram_adr=0; dat_out=0; dat_oe=0; all *_n=1.
- Accept = req_valid & req_ready at a rising edge. The block latches addr, wdata, be, and we. If req_valid is high while req_ready is low, the request is ignored; the requester holds it.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_STROBE. A 4-bit wait counter is loaded on entry to WR_PULSE/RD_STROBE.
- IDLE: cs_n=oe_n=we_n=lb_n=ub_n=1, dat_oe=0, ram_adr holds its last value.
- Write: WR_SETUP (1 cycle): adr/dat_out driven, dat_oe=1, cs_n=0, lb_n/ub_n per byte mask, we_n=1.
  - WR_PULSE (WR_WAIT+1 cycles): we_n=0.
  - WR_HOLD (1 cycle): we_n=1, data and address held.
  - Then IDLE. req_ready returns WR_WAIT+4 cycles after the accept edge.
- Read: RD_STROBE (RD_WAIT+1 cycles): cs_n=0, oe_n=0, lb_n=ub_n=0, dat_oe=0. dat_in is captured into rsp_rdata at the final RD_STROBE edge, then the block returns to IDLE. rsp_valid is high for exactly that following IDLE cycle. Read latency: rsp_valid asserts RD_WAIT+2 cycles after the accept edge.
- A new accept in the same cycle rsp_valid is high is legal (back-to-back).
- Bus safety invariant: dat_oe=1 and ram_oe_n=0 never occur in the same cycle. A read→write sequence always passes through one IDLE cycle with both deasserted.
- rsp_rdata holds its value until the next read completes.
- rst asserted mid-operation: next edge forces IDLE and reset output values. An in-flight read produces no rsp_valid; an in-flight write aborts with we_n=1.

Optional Feature:
- SRAM_BYTE_MASK_EN defined: write cycles drive ram_lb_n=~req_be[0] and ram_ub_n=~req_be[1] as latched. A write with req_be=2'b00 is still sequenced, but no byte is written.
- SRAM_BYTE_MASK_EN undefined: req_be is ignored and lb_n=ub_n=0 for every write. Reads always enable both bytes in either build.

Test Plan:
- Reset, then write addr 0x00010 data 0xA5C3 with WR_WAIT=1 → we_n low exactly 2 cycles, dat_oe high 4 cycles, req_ready returns 5 cycles after accept.
- Read 0x00010 with the SRAM model returning 0xA5C3 and RD_WAIT=1 → oe_n low 2 cycles, rsp_valid single pulse 3 cycles after accept, rsp_rdata=0xA5C3.
- Back-to-back read 0x7FFFF then write 0x00000 → one IDLE gap; checker confirms dat_oe and ~oe_n are never both high; ram_adr wraps correctly at the top address.
- With SRAM_BYTE_MASK_EN, write 0x1234 with be=2'b10 over 0xFFFF → readback 0x12FF. Without the macro, the same stimulus reads back 0x1234.
- Assert rst in the 2nd RD_STROBE cycle → all strobes high next cycle, no rsp_valid, req_ready=1 one cycle after rst drops.
- Hold req_valid high while busy with a changing address → only the value present at the accept edge is used; the request is accepted once, on the ready edge.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port controller for a 512K x 16 asynchronous SRAM.
// Turns one-word valid/ready requests into registered CS/OE/WE/LB/UB
// strobe sequences and returns read data with a one-cycle rsp_valid pulse.
//
// Ports:
//   clk, rst                 100 MHz clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we/addr/wdata/be     request fields, latched on accept
//   rsp_valid/rsp_rdata      read response pulse and held read data
//   ram_adr, dat_out, dat_oe address and data-out path to the pads
//   dat_in                   data-in path from the pads
//   ram_*_n                  active-low SRAM strobes
//
// Build option: define SRAM_BYTE_MASK_EN to honour req_be on writes;
// otherwise both byte lanes are written on every write.
module sram_ctrl #(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] dat_out,
    input  logic [DATA_W-1:0] dat_in,
    output logic              dat_oe,
    output logic              ram_cs_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              ram_lb_n,
    output logic              ram_ub_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_RD_STROBE
    } state_t;

    localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       w_accept;

    assign w_accept = req_valid & req_ready;

`ifndef SRAM_BYTE_MASK_EN
    logic w_unused_be;
    assign w_unused_be = ^req_be;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ram_adr   <= '0;
            dat_out   <= '0;
            dat_oe    <= 1'b0;
            ram_cs_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_lb_n  <= 1'b1;
            ram_ub_n  <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        req_ready <= 1'b0;
                        ram_adr   <= req_addr;
                        ram_cs_n  <= 1'b0;
                        if (req_we) begin
                            r_state <= S_WR_SETUP;
                            dat_out <= req_wdata;
                            dat_oe  <= 1'b1;
`ifdef SRAM_BYTE_MASK_EN
                            ram_lb_n <= ~req_be[0];
                            ram_ub_n <= ~req_be[1];
`else
                            ram_lb_n <= 1'b0;
                            ram_ub_n <= 1'b0;
`endif
                        end else begin
                            r_state  <= S_RD_STROBE;
                            r_cnt    <= RD_CNT;
                            ram_oe_n <= 1'b0;
                            ram_lb_n <= 1'b0;
                            ram_ub_n <= 1'b0;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_WR_SETUP: begin
                    r_state  <= S_WR_PULSE;
                    r_cnt    <= WR_CNT;
                    ram_we_n <= 1'b0;
                end
                S_WR_PULSE: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= S_WR_HOLD;
                        ram_we_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WR_HOLD: begin
                    // Data and address stay put one cycle past WE rising.
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                    dat_oe    <= 1'b0;
                    ram_cs_n  <= 1'b1;
                    ram_lb_n  <= 1'b1;
                    ram_ub_n  <= 1'b1;
                end
                S_RD_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        // OE deasserts here, so a following write's
                        // dat_oe cannot overlap it.
                        r_state   <= S_IDLE;
                        rsp_rdata <= dat_in;
                        rsp_valid <= 1'b1;
                        req_ready <= 1'b1;
                        ram_cs_n  <= 1'b1;
                        ram_oe_n  <= 1'b1;
                        ram_lb_n  <= 1'b1;
                        ram_ub_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized self-checking bench for sram_ctrl.
// Pin-level SRAM model plus a word-level reference memory.
module tb_sram_ctrl;

    localparam int AW  = 19;
    localparam int DW  = 16;
    localparam int RDW = 1;
    localparam int WRW = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [1:0]    req_be;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] dat_out;
    logic [DW-1:0] dat_in;
    logic          dat_oe;
    logic          ram_cs_n;
    logic          ram_oe_n;
    logic          ram_we_n;
    logic          ram_lb_n;
    logic          ram_ub_n;

    always #5 clk = ~clk;

    sram_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_WAIT(RDW),
        .WR_WAIT(WRW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .ram_adr  (ram_adr),
        .dat_out  (dat_out),
        .dat_in   (dat_in),
        .dat_oe   (dat_oe),
        .ram_cs_n (ram_cs_n),
        .ram_oe_n (ram_oe_n),
        .ram_we_n (ram_we_n),
        .ram_lb_n (ram_lb_n),
        .ram_ub_n (ram_ub_n)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pin-level SRAM: stores lanes while CS and WE are low, drives data
    // while CS and OE are low, junk otherwise.
    logic [15:0] sram [int];

    function automatic logic [15:0] sram_get(input int i);
        return sram.exists(i) ? sram[i] : 16'h0000;
    endfunction

    always @(posedge clk) begin
        logic [15:0] v;
        if (!ram_cs_n && !ram_we_n) begin
            v = sram_get(int'(ram_adr));
            if (!ram_lb_n) v[7:0] = dat_out[7:0];
            if (!ram_ub_n) v[15:8] = dat_out[15:8];
            sram[int'(ram_adr)] = v;
        end
    end

    always @(negedge clk) begin
        if (!ram_cs_n && !ram_oe_n) dat_in <= sram_get(int'(ram_adr));
        else dat_in <= 16'($urandom);
    end

    // Word-level reference: what a read of an address should return.
    logic [15:0] ref_mem [int];

    function automatic logic [15:0] ref_get(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    task automatic ref_wr(input int a, input logic [15:0] d,
                          input logic [1:0] be);
        logic [15:0] o;
        o = ref_get(a);
`ifdef SRAM_BYTE_MASK_EN
        ref_mem[a] = {be[1] ? d[15:8] : o[15:8], be[0] ? d[7:0] : o[7:0]};
`else
        ref_mem[a] = d;
`endif
    endtask

    // Monitors.
    int n_bus_viol = 0;
    int n_rsp      = 0;
    int n_long     = 0;
    int n_acc      = 0;
    logic prev_rsp = 1'b0;

    always @(negedge clk) begin
        if (dat_oe && !ram_oe_n) n_bus_viol++;
        if (rsp_valid) n_rsp++;
        if (rsp_valid && prev_rsp) n_long++;
        prev_rsp <= rsp_valid;
    end

    always @(posedge clk) begin
        if (!rst && req_valid && req_ready) n_acc++;
    end

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) check(tag, 0, 1);
    endtask

    task automatic scramble();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = 16'($urandom);
        req_be    = 2'($urandom);
    endtask

    // Called at a negedge; returns at the negedge where ready is back.
    task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d,
                            input logic [1:0] be, output int lat,
                            output int n_we, output int n_doe,
                            output logic [AW-1:0] adr1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        wait_ready("wr_accept_timeout");
        @(posedge clk);
        #1 scramble();
        lat   = 0;
        n_we  = 0;
        n_doe = 0;
        adr1  = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) adr1 = ram_adr;
            if (!ram_we_n) n_we++;
            if (dat_oe) n_doe++;
        end while (!req_ready && lat < 100);
        ref_wr(int'(a), d, be);
    endtask

    // Returns at the negedge where rsp_valid is high.
    task automatic do_read(input logic [AW-1:0] a, output int lat,
                           output int n_oe, output logic [15:0] rd,
                           output logic [AW-1:0] adr1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        wait_ready("rd_accept_timeout");
        @(posedge clk);
        #1 scramble();
        lat  = 0;
        n_oe = 0;
        adr1 = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) adr1 = ram_adr;
            if (!ram_oe_n) n_oe++;
        end while (!rsp_valid && lat < 100);
        rd = rsp_rdata;
        check("rd_ready_at_rsp", 32'(req_ready), 1);
    endtask

    function automatic logic [31:0] strobes();
        return 32'({ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n});
    endfunction

    initial begin
        int lat, nwe, ndoe, noe, acc0, rsp0;
        logic [15:0] rd;
        logic [AW-1:0] adr1;
        logic [AW-1:0] pool [8];
        logic [15:0] exp_bm;

        rst = 1'b1;
        scramble();
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rdata", 32'(rsp_rdata), 0);
        check("rst_adr", 32'(ram_adr), 0);
        check("rst_dat_out", 32'(dat_out), 0);
        check("rst_dat_oe", 32'(dat_oe), 0);
        check("rst_strobes", strobes(), 32'h1f);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 1);

        // Directed write and read.
        do_write(19'h00010, 16'hA5C3, 2'b11, lat, nwe, ndoe, adr1);
        check("wr_latency", 32'(lat), 32'(WRW + 4));
        check("wr_we_low", 32'(nwe), 32'(WRW + 1));
        check("wr_dat_oe", 32'(ndoe), 32'(WRW + 3));
        check("wr_adr", 32'(adr1), 32'h10);
        check("wr_idle_strobes", strobes(), 32'h1f);
        do_read(19'h00010, lat, noe, rd, adr1);
        check("rd_latency", 32'(lat), 32'(RDW + 2));
        check("rd_oe_low", 32'(noe), 32'(RDW + 1));
        check("rd_data", 32'(rd), 32'hA5C3);
        @(negedge clk);
        check("rsp_pulse_end", 32'(rsp_valid), 0);
        check("rdata_hold", 32'(rsp_rdata), 32'hA5C3);

        // Back-to-back read at the top address then write at zero.
        do_write(19'h7FFFF, 16'h5A5A, 2'b11, lat, nwe, ndoe, adr1);
        do_read(19'h7FFFF, lat, noe, rd, adr1);
        check("top_adr", 32'(adr1), 32'h7FFFF);
        check("top_data", 32'(rd), 32'h5A5A);
        do_write(19'h00000, 16'h0F0F, 2'b11, lat, nwe, ndoe, adr1);
        check("b2b_wr_latency", 32'(lat), 32'(WRW + 4));
        check("zero_adr", 32'(adr1), 32'h0);
        do_read(19'h00000, lat, noe, rd, adr1);
        check("zero_data", 32'(rd), 32'h0F0F);

        // Byte mask.
        do_write(19'h00123, 16'hFFFF, 2'b11, lat, nwe, ndoe, adr1);
        do_write(19'h00123, 16'h1234, 2'b10, lat, nwe, ndoe, adr1);
        do_read(19'h00123, lat, noe, rd, adr1);
`ifdef SRAM_BYTE_MASK_EN
        exp_bm = 16'h12FF;
`else
        exp_bm = 16'h1234;
`endif
        check("byte_mask", 32'(rd), 32'(exp_bm));
        check("byte_mask_ref", 32'(rd), 32'(ref_get(32'h123)));

        // Reset during the second read-strobe cycle.
        @(posedge clk);
        #1 rsp0 = n_rsp;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 19'h00010;
        wait_ready("rst_rd_accept_timeout");
        @(posedge clk);
        #1 scramble();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_strobes", strobes(), 32'h1f);
        check("midrst_rsp", 32'(rsp_valid), 0);
        check("midrst_ready", 32'(req_ready), 0);
        check("midrst_dat_oe", 32'(dat_oe), 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_back", 32'(req_ready), 1);
        repeat (3) @(posedge clk);
        #1 check("midrst_no_rsp", 32'(n_rsp - rsp0), 0);
        @(negedge clk);

        // Request held while busy with a changing address.
        @(posedge clk);
        #1 acc0 = n_acc;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 19'h00200;
        req_wdata = 16'h1111;
        req_be    = 2'b11;
        wait_ready("hold_accept1_timeout");
        @(posedge clk);
        #1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!req_ready) begin
                req_addr  = AW'($urandom);
                req_wdata = 16'h2222;
            end
        end while (!req_ready && lat < 100);
        req_addr = 19'h00300;
        @(posedge clk);
        #1 scramble();
        ref_wr(32'h200, 16'h1111, 2'b11);
        ref_wr(32'h300, 16'h2222, 2'b11);
        @(negedge clk);
        check("hold_adr", 32'(ram_adr), 32'h300);
        wait_ready("hold_drain_timeout");
        @(posedge clk);
        #1 check("hold_accepts", 32'(n_acc - acc0), 2);
        @(negedge clk);
        do_read(19'h00300, lat, noe, rd, adr1);
        check("hold_data2", 32'(rd), 32'(ref_get(32'h300)));
        do_read(19'h00200, lat, noe, rd, adr1);
        check("hold_data1", 32'(rd), 32'(ref_get(32'h200)));

        // Random mix against the reference memory.
        for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
        for (int i = 0; i < 60; i++) begin
            logic [AW-1:0] a;
            a = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, 16'($urandom), 2'($urandom), lat, nwe, ndoe,
                         adr1);
                check("rnd_wr_latency", 32'(lat), 32'(WRW + 4));
                check("rnd_wr_adr", 32'(adr1), 32'(a));
            end else begin
                do_read(a, lat, noe, rd, adr1);
                check("rnd_rd_latency", 32'(lat), 32'(RDW + 2));
                check("rnd_rd_data", 32'(rd), 32'(ref_get(int'(a))));
            end
        end

        repeat (3) @(negedge clk);
        check("bus_safety", 32'(n_bus_viol), 0);
        check("rsp_single_pulse", 32'(n_long), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
